// File: rtl/task_issue_queue.sv
// task_issue_queue: buffers commands and issues them one at a time to a toggle task/ack crossing.
module task_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 2,
    parameter int TIMEOUT_WIDTH = 16,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  task_start,
    output logic [DATA_WIDTH-1:0] task_data,
    input  logic                  task_busy,
    input  logic                  task_done,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  timeout_err,
    input  logic                  err_clear,
    output logic [DEPTH_LOG2:0]   pending,
    output logic                  idle
);
    localparam int Depth = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t                   state, stateNext;
    logic [DATA_WIDTH-1:0]    mem [Depth];
    logic [DEPTH_LOG2-1:0]    wrPtr, rdPtr;
    logic [DEPTH_LOG2:0]      pendingQ;
    logic [TIMEOUT_WIDTH-1:0] watchdog, wdNext;
    logic                     push, pop, retire, timeoutHit;

    // Full exactly when the pending count reaches Depth, i.e. its MSB is set.
    assign cmd_ready  = ~pendingQ[DEPTH_LOG2];
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == IDLE) && (pendingQ != '0) && !task_busy;
    assign retire     = (state == WAIT_DONE) && task_done;
    assign wdNext     = (watchdog == '1) ? watchdog : watchdog + TIMEOUT_WIDTH'(1);
    assign timeoutHit = (TIMEOUT_CYCLES != '0) && (state == WAIT_DONE) && !task_done
                        && (wdNext == TIMEOUT_CYCLES);
    assign task_start = (state == ISSUE);
    assign idle       = (state == IDLE) && (pendingQ == '0);
    assign pending    = pendingQ;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      stateNext = pop ? ISSUE : IDLE;
            ISSUE:     stateNext = WAIT_DONE;
            WAIT_DONE: stateNext = task_done ? IDLE : WAIT_DONE;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= cmd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wrPtr       <= '0;
            rdPtr       <= '0;
            pendingQ    <= '0;
            task_data   <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            timeout_err <= 1'b0;
            watchdog    <= '0;
        end else begin
            state <= stateNext;
            if (push) wrPtr <= wrPtr + DEPTH_LOG2'(1);
            if (pop) begin
                rdPtr     <= rdPtr + DEPTH_LOG2'(1);
                task_data <= mem[rdPtr];
            end
            if (push && !pop) pendingQ <= pendingQ + (DEPTH_LOG2+1)'(1);
            else if (pop && !push) pendingQ <= pendingQ - (DEPTH_LOG2+1)'(1);
            rsp_valid <= retire;
            if (retire) rsp_data <= task_data;
            if (state == ISSUE) watchdog <= '0;
            else if (state == WAIT_DONE && !task_done) watchdog <= wdNext;
            // The crossing cannot abort, so a timeout only flags; set wins over clear.
            if (timeoutHit) timeout_err <= 1'b1;
            else if (err_clear) timeout_err <= 1'b0;
        end
    end
endmodule
